// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC width, sequential step and the
// next-PC controller state encoding.
package pipe_pkg;

  localparam int          PC_W    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } pc_seq_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: redirect (or trap vector), sequential
// advance, or hold. Build option PC_SEQ_TRAP_EN routes misaligned redirect
// targets to TRAP_VEC; without it the target is taken verbatim.
module pc_next_mux
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [PC_W-1:0] pc_cur,
  input  logic [PC_W-1:0] pc_inc,
  input  logic [PC_W-1:0] br_target,
  input  logic            redirect,
  input  logic            advance,
  output logic [PC_W-1:0] pc_next,
  output logic            misaligned
);

  assign misaligned = redirect & (br_target[1:0] != 2'b00);

`ifndef PC_SEQ_TRAP_EN
  // Trap vector is only meaningful when misaligned targets are trapped.
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // Redirect beats advance; anything else holds the current PC.
  always_comb begin
    pc_next = pc_cur;
    if (redirect) begin
`ifdef PC_SEQ_TRAP_EN
      pc_next = misaligned ? TRAP_VEC : br_target;
`else
      pc_next = br_target;
`endif
    end else if (advance) begin
      pc_next = pc_inc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the RV32I pipeline. Selects the next PC from redirect,
// sequential advance, hazard hold or memory wait and drives the IF/ID and
// ID/EX enable/flush controls. Build option PC_SEQ_TRAP_EN adds the
// misaligned-target trap and the misalign_trap pulse output.
//
// state    | meaning
// ---------+----------------------------------------------------------
// BOOT     | one cycle after reset, no fetch, IF/ID held as a bubble
// RUN      | fetching, PC advances when the instruction returns
// WAIT_MEM | fetch outstanding, PC held until imem_ready
// HALT     | ebreak seen, fetch stopped until reset
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            hazard_stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc_if,
  output logic [PC_W-1:0] pc_plus4,
  output logic            if_id_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            halted
`ifdef PC_SEQ_TRAP_EN
  ,output logic           misalign_trap
`endif
);

  pc_seq_state_t   state, state_nxt;
  logic [PC_W-1:0] pc_next;
  logic            active, redirect, advance, misaligned;

  assign active    = (state == RUN) || (state == WAIT_MEM);
  assign redirect  = active & br_taken;
  assign advance   = active & ~br_taken & ~halt_req & ~hazard_stall & imem_ready;
  assign pc_plus4  = pc_if + PC_STEP;
  assign imem_addr = pc_if;

  pc_next_mux #(.TRAP_VEC(TRAP_VEC)) u_next_mux (
    .pc_cur     (pc_if),
    .pc_inc     (pc_plus4),
    .br_target  (br_target),
    .redirect   (redirect),
    .advance    (advance),
    .pc_next    (pc_next),
    .misaligned (misaligned)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc_if <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_if <= pc_next;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  // One-cycle pulse following a redirect to a misaligned target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_trap <= 1'b0;
    else      misalign_trap <= misaligned;
  end
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif

  // Next state in redirect > halt > stall > memory-wait priority, plus
  // the combinational pipeline controls.
  always_comb begin
    state_nxt   = state;
    imem_req    = active;
    if_id_en    = active & imem_ready & ~hazard_stall;
    if_id_flush = br_taken |
                  (((state == BOOT) | (state == HALT) | ~imem_ready) & ~hazard_stall);
    id_ex_flush = br_taken | hazard_stall;
    halted      = (state == HALT);
    case (state)
      BOOT:          state_nxt = RUN;
      RUN, WAIT_MEM: begin
        if (br_taken)          state_nxt = RUN;
        else if (halt_req)     state_nxt = HALT;
        else if (hazard_stall) state_nxt = state;
        else if (!imem_ready)  state_nxt = WAIT_MEM;
        else                   state_nxt = RUN;
      end
      HALT:          state_nxt = HALT;
      default:       state_nxt = BOOT;
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the RV32I pipeline. It owns the fetch program counter and selects the next PC each cycle from sequential, branch/jump redirect, hazard hold or memory wait. It drives the instruction-memory fetch request and the IF/ID and ID/EX enable and flush controls. It sits between the EX-stage branch resolution, the ID-stage hazard unit and instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded by reset and fetched first
- TRAP_VEC, 32'h0000_0100, redirect target for a misaligned branch target (only with PC_SEQ_TRAP_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, equal to pc_if
- imem_ready  in  1  instruction returned for imem_addr this cycle
- hazard_stall  in  1  load-use stall from the ID hazard unit
- br_taken  in  1  EX-stage taken branch or jump
- br_target  in  32  redirect address, valid with br_taken
- halt_req  in  1  ID-stage ebreak: stop fetching
- pc_if  out  32  current fetch PC
- pc_plus4  out  32  pc_if + 4, modulo 2^32
- if_id_en  out  1  IF/ID register write enable
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_flush  out  1  ID/EX loads a bubble
- halted  out  1  sequencer is in HALT
- misalign_trap  out  1  one-cycle pulse; only with PC_SEQ_TRAP_EN

## Operation
- FSM states: BOOT, RUN, WAIT_MEM, HALT.
- Reset (rst=0) is asynchronous:
  - state=BOOT, pc_if=RESET_PC, misalign_trap=0.
  - Combinational outputs take their BOOT values: imem_req=0, if_id_en=0, if_id_flush=1, id_ex_flush=0, halted=0.
- BOOT: on the next edge, go to RUN and hold the PC.
- In RUN and WAIT_MEM, evaluate in priority order:
  1. br_taken: pc_if<=br_target; state<=RUN.
  2. halt_req: hold the PC; state<=HALT.
  3. hazard_stall: hold the PC; state is unchanged.
  4. !imem_ready: hold the PC; state<=WAIT_MEM.
  5. Otherwise: pc_if<=pc_if+4; state<=RUN.
- HALT: hold the PC. Only reset exits HALT.
- imem_req = RUN or WAIT_MEM.
- if_id_en = (RUN or WAIT_MEM) & imem_ready & ~hazard_stall.
- if_id_flush = br_taken | ((BOOT | HALT | ~imem_ready) & ~hazard_stall).
- id_ex_flush = br_taken | hazard_stall.
- halted = (state==HALT).
- Simultaneous events:
  - br_taken with hazard_stall: the redirect wins, and both flushes assert.
  - br_taken with halt_req: the redirect wins, because the halting instruction is on the wrong path.
- Wrap-around: pc_if=32'hFFFF_FFFC advances to 32'h0000_0000. No flag is raised.
- br_target is used unmodified when PC_SEQ_TRAP_EN is undefined.

## Timing
- Redirect latency: br_taken in cycle N gives pc_if=br_target in cycle N+1. Both flushes are combinational in cycle N.
- First fetch: rst rises before edge E0. BOOT occupies E0, and imem_req=1 with pc_if=RESET_PC from E0 onward.
- Sequential throughput: one PC per cycle while imem_ready=1.
- Stall hold: pc_if is held for exactly as many cycles as hazard_stall is high.
- All flush/enable outputs are combinational from the state and inputs; there are no registered outputs except pc_if, state and misalign_trap.

## Configuration
- PC_SEQ_TRAP_EN defined:
  - A br_taken with br_target[1:0]!=0 redirects to TRAP_VEC instead of br_target.
  - misalign_trap is registered high for the one cycle after that edge.
- PC_SEQ_TRAP_EN undefined:
  - The misalign_trap port and its logic are absent.
  - Targets are taken verbatim.

## Structure
- Shared package pipe_pkg holds:
  - the state enum pc_seq_state_t {BOOT, RUN, WAIT_MEM, HALT};
  - the constants PC_W=32 and PC_STEP=4.
- One natural sub-module, pc_next_mux: a combinational next-PC select over sequential, redirect, trap and hold. The FSM and the PC register stay in pc_sequencer.

## Test plan
- Reset release, imem_ready=1 → pc_if sequence 0x0 (BOOT), 0x0, 0x4, 0x8; imem_req=0 only in BOOT.
- br_taken=1 with br_target=0x200 at pc_if=0x10 → if_id_flush=id_ex_flush=1 that cycle; pc_if=0x200, then 0x204.
- hazard_stall high for 2 cycles at pc_if=0x20 → pc_if stays 0x20 for 2 cycles; if_id_en=0, id_ex_flush=1, if_id_flush=0; then 0x24.
- imem_ready low for 3 cycles → state WAIT_MEM, pc_if held, if_id_flush=1; advance on the first ready.
- halt_req at pc_if=0x40 → halted=1, imem_req=0, pc_if stays 0x40; async rst mid-HALT → pc_if=RESET_PC immediately.
- PC_SEQ_TRAP_EN defined, br_target=0x202 → pc_if=0x100, misalign_trap one-cycle pulse. Also check wrap: pc_if 0xFFFFFFFC → 0x0.
